// File: rtl/fxy_sweep_ctrl.sv
// fxy_sweep_ctrl
// Exhaustive sweep sequencer for a 4-input combinational function block.
// On an accepted start it walks the 16 input vectors in truth-table order.
// Each vector is held for SETTLE cycles, and then the function output is
// captured into a 16-bit table. The captured table is compared against a
// reference latched at start.
//
// Ports
//   clk_i              clock, rising edge
//   rst_n_i            synchronous active-low reset
//   start_i            sweep request, honoured only in IDLE
//   expected_i[15:0]   reference truth table (bit i = expected s at index i)
//   x_o,y_o,w_o,z_o    function inputs = idx[3],idx[2],idx[1],idx[0]
//   s_i                function output
//   busy_o             sweep in progress (WAIT/SAMPLE/DONE)
//   done_o             one-cycle pulse when results are final
//   pass_o             last sweep had zero mismatches
//   table_o[15:0]      captured truth table
//   mismatch_count_o   mismatches in last sweep, 0..16
//   first_fail_o       lowest mismatching index (valid with first_fail_valid_o)
//   first_fail_valid_o any mismatch seen in the current sweep
module fxy_sweep_ctrl #(
   parameter int unsigned SETTLE = 1   // legal range 1..15
) (
   input  logic        clk_i,
   input  logic        rst_n_i,
   input  logic        start_i,
   input  logic [15:0] expected_i,
   output logic        x_o,
   output logic        y_o,
   output logic        w_o,
   output logic        z_o,
   input  logic        s_i,
   output logic        busy_o,
   output logic        done_o,
   output logic        pass_o,
   output logic [15:0] table_o,
   output logic [4:0]  mismatch_count_o,
   output logic [3:0]  first_fail_o,
   output logic        first_fail_valid_o
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT,
      ST_SAMPLE,
      ST_DONE
   } state_t;

   localparam logic [3:0] SETTLE_C = 4'(SETTLE);

   state_t      state_q, state_d;
   logic [3:0]  idx_q, idx_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [15:0] exp_q, exp_d;
   logic [15:0] tbl_q, tbl_d;
   logic [4:0]  mcnt_q, mcnt_d;
   logic [3:0]  ff_q, ff_d;
   logic        ffv_q, ffv_d;
   logic        pass_q, pass_d;
   logic        mis;

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         state_q <= ST_IDLE;
         idx_q   <= '0;
         cnt_q   <= '0;
         exp_q   <= '0;
         tbl_q   <= '0;
         mcnt_q  <= '0;
         ff_q    <= '0;
         ffv_q   <= 1'b0;
         pass_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
         exp_q   <= exp_d;
         tbl_q   <= tbl_d;
         mcnt_q  <= mcnt_d;
         ff_q    <= ff_d;
         ffv_q   <= ffv_d;
         pass_q  <= pass_d;
      end
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      exp_d   = exp_q;
      tbl_d   = tbl_q;
      mcnt_d  = mcnt_q;
      ff_d    = ff_q;
      ffv_d   = ffv_q;
      pass_d  = pass_q;
      mis     = (s_i != exp_q[idx_q]);

      case (state_q)
         ST_IDLE: begin
            idx_d = '0;
            if (start_i) begin
               exp_d   = expected_i;
               tbl_d   = '0;
               mcnt_d  = '0;
               ff_d    = '0;
               ffv_d   = 1'b0;
               pass_d  = 1'b0;
               cnt_d   = SETTLE_C;
               state_d = ST_WAIT;
            end
         end
         ST_WAIT: begin
            // Loaded with SETTLE, leave on the edge where it reads 1:
            // exactly SETTLE cycles in WAIT.
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) state_d = ST_SAMPLE;
         end
         ST_SAMPLE: begin
            tbl_d[idx_q] = s_i;
            if (mis) begin
               mcnt_d = mcnt_q + 5'd1;
               if (!ffv_q) begin
                  ff_d  = idx_q;
                  ffv_d = 1'b1;
               end
            end
            if (idx_q == 4'd15) begin
               // Uses the updated count so the last vector is included.
               pass_d  = (mcnt_d == 5'd0);
               state_d = ST_DONE;
            end else begin
               idx_d   = idx_q + 4'd1;
               cnt_d   = SETTLE_C;
               state_d = ST_WAIT;
            end
         end
         ST_DONE: begin
            idx_d   = '0;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign x_o                = idx_q[3];
   assign y_o                = idx_q[2];
   assign w_o                = idx_q[1];
   assign z_o                = idx_q[0];
   assign busy_o             = (state_q != ST_IDLE);
   assign done_o             = (state_q == ST_DONE);
   assign pass_o             = pass_q;
   assign table_o            = tbl_q;
   assign mismatch_count_o   = mcnt_q;
   assign first_fail_o       = ff_q;
   assign first_fail_valid_o = ffv_q;

endmodule

// File: tb/tb_fxy_sweep_ctrl.sv
// Directed bench for fxy_sweep_ctrl: one instance with SETTLE=1 driven by a
// truth-table model of fxy (16'h3526), and one with SETTLE=3 with s tied high.
module tb_fxy_sweep_ctrl;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic        start1, start3;
   logic [15:0] exp1, exp3;

   logic        x1, y1, w1, z1, s1, busy1, done1, pass1, ffv1;
   logic [15:0] tbl1;
   logic [4:0]  mc1;
   logic [3:0]  ff1;

   logic        x3, y3, w3, z3, s3, busy3, done3, pass3, ffv3;
   logic [15:0] tbl3;
   logic [4:0]  mc3;
   logic [3:0]  ff3;

   logic [15:0] fxy_tt;
   assign s1 = fxy_tt[{x1, y1, w1, z1}];
   assign s3 = 1'b1;

   int total = 0;
   int bad   = 0;
   int dones1 = 0;

   always @(negedge clk) if (done1 === 1'b1) dones1++;

   fxy_sweep_ctrl dut1 (
      .clk_i(clk), .rst_n_i(rst_n), .start_i(start1), .expected_i(exp1),
      .x_o(x1), .y_o(y1), .w_o(w1), .z_o(z1), .s_i(s1),
      .busy_o(busy1), .done_o(done1), .pass_o(pass1), .table_o(tbl1),
      .mismatch_count_o(mc1), .first_fail_o(ff1), .first_fail_valid_o(ffv1)
   );

   fxy_sweep_ctrl #(.SETTLE(3)) dut3 (
      .clk_i(clk), .rst_n_i(rst_n), .start_i(start3), .expected_i(exp3),
      .x_o(x3), .y_o(y3), .w_o(w3), .z_o(z3), .s_i(s3),
      .busy_o(busy3), .done_o(done3), .pass_o(pass3), .table_o(tbl3),
      .mismatch_count_o(mc3), .first_fail_o(ff3), .first_fail_valid_o(ffv3)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // Advance n rising edges, then settle 1 time unit past the last one.
   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Full SETTLE=1 sweep starting from IDLE; ends one edge after DONE.
   task automatic run1(input string tag, input logic [15:0] e, input logic [15:0] tt_e,
                       input logic pass_e, input logic [4:0] mc_e,
                       input logic [3:0] ff_e, input logic ffv_e);
      int d0;
      d0 = dones1;
      exp1 = e; start1 = 1'b1;
      tick(1);                             // after E0
      start1 = 1'b0;
      chk({tag, ".busy"}, busy1, 1);
      for (int i = 0; i < 16; i++) begin   // vector i visible after E(2i)
         chk({tag, ".vec"}, {x1, y1, w1, z1}, i);
         tick(2);
      end                                   // after E32
      chk({tag, ".done"}, done1, 1);
      chk({tag, ".table"}, tbl1, tt_e);
      chk({tag, ".pass"}, pass1, pass_e);
      chk({tag, ".mcnt"}, mc1, mc_e);
      chk({tag, ".ff"}, ff1, ff_e);
      chk({tag, ".ffv"}, ffv1, ffv_e);
      tick(1);                             // after E33, back in IDLE
      chk({tag, ".busy_off"}, busy1, 0);
      chk({tag, ".done_off"}, done1, 0);
      chk({tag, ".hold"}, tbl1, tt_e);
      chk({tag, ".ndone"}, dones1 - d0, 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin
      int d0;
      fxy_tt = 16'h3526;
      rst_n = 1'b0; start1 = 1'b1; start3 = 1'b0;   // start ignored under reset
      exp1 = 16'hFFFF; exp3 = 16'h0000;

      // Reset
      tick(3);
      chk("rst.busy", busy1, 0);
      chk("rst.done", done1, 0);
      chk("rst.pass", pass1, 0);
      chk("rst.table", tbl1, 0);
      chk("rst.mcnt", mc1, 0);
      chk("rst.ff", {ffv1, ff1}, 0);
      chk("rst.xywz", {x1, y1, w1, z1}, 0);
      chk("rst.dut3", {busy3, done3, pass3, tbl3, mc3, ff3, ffv3, x3, y3, w3, z3}, 0);
      start1 = 1'b0; rst_n = 1'b1;
      tick(1);

      // Good sweep, then mismatch patterns
      run1("good",  16'h3526, 16'h3526, 1'b1, 5'd0,  4'd0,  1'b0);
      run1("mis2",  16'h3525, 16'h3526, 1'b0, 5'd2,  4'd0,  1'b1);
      run1("mis16", 16'hCAD9, 16'h3526, 1'b0, 5'd16, 4'd0,  1'b1);
      run1("mis15", 16'hB526, 16'h3526, 1'b0, 5'd1,  4'd15, 1'b1);

      // Start during a sweep is ignored; expected stays latched
      d0 = dones1;
      exp1 = 16'h3526; start1 = 1'b1;
      tick(1);                             // E0
      start1 = 1'b0;
      tick(9);                             // after E9
      start1 = 1'b1; exp1 = 16'h0000;
      tick(1);                             // after E10
      start1 = 1'b0;
      chk("bs.busy", busy1, 1);
      tick(21);                            // after E31
      chk("bs.nodone31", done1, 0);
      tick(1);                             // after E32
      chk("bs.done32", done1, 1);
      chk("bs.pass", pass1, 1);
      start1 = 1'b1; exp1 = 16'h3526;      // held high across DONE
      tick(1);                             // after E33
      chk("bs.idle", busy1, 0);
      chk("bs.ndone", dones1 - d0, 1);
      tick(1);                             // after E34: retriggered
      chk("bs.retrig", busy1, 1);
      start1 = 1'b0;
      tick(32);                            // after E66
      chk("bs.done2", done1, 1);
      chk("bs.table2", tbl1, 16'h3526);
      tick(1);

      // Reset mid-sweep
      exp1 = 16'h3526; start1 = 1'b1;
      tick(1);
      start1 = 1'b0;
      tick(9);                             // after E9: idx 0..3 sampled
      chk("mr.partial", tbl1, 16'h0006);
      rst_n = 1'b0;
      tick(1);                             // after E10
      chk("mr.busy", busy1, 0);
      chk("mr.table", tbl1, 0);
      chk("mr.xywz", {x1, y1, w1, z1}, 0);
      rst_n = 1'b1;
      tick(1);
      run1("after_rst", 16'h3526, 16'h3526, 1'b1, 5'd0, 4'd0, 1'b0);

      // SETTLE=3
      exp3 = 16'hFFFF; start3 = 1'b1;
      tick(1);                             // E0
      start3 = 1'b0;
      chk("s3.busy", busy3, 1);
      tick(3);                             // after E3
      chk("s3.hold0", {x3, y3, w3, z3}, 0);
      tick(1);                             // after E4
      chk("s3.vec1", {x3, y3, w3, z3}, 1);
      tick(59);                            // after E63
      chk("s3.nodone63", done3, 0);
      tick(1);                             // after E64
      chk("s3.done64", done3, 1);
      chk("s3.pass", pass3, 1);
      chk("s3.table", tbl3, 16'hFFFF);
      chk("s3.mcnt", mc3, 0);
      tick(1);
      chk("s3.busy_off", busy3, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/fxy_sweep_ctrl.md
# fxy_sweep_ctrl

Sequencer that exhaustively exercises a 4-input combinational function block (e.g. the team's `fxy` sum-of-products function) in hardware. On a start pulse it steps the 16 input vectors in truth-table order, waits a programmable settle time per vector, and captures the output into a 16-bit truth-table register. It compares the captured table against a reference mask, then reports pass/fail, the mismatch count and the first failing index through a start/done handshake. It sits between the function under test and a self-check or status block.

## Interface
- `SETTLE`, default 1: cycles each vector is held before sampling; legal range 1..15.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `start` in 1: sweep request, sampled only in IDLE.
- `expected` in 16: reference truth table; bit i is the expected `s` for index i. Latched at start.
- `x`, `y`, `w`, `z` out 1 each: drive the function inputs; `x` = idx[3], `y` = idx[2], `w` = idx[1], `z` = idx[0].
- `s` in 1: function output.
- `busy` out 1: high from the cycle after start is accepted until DONE is left.
- `done` out 1: one-cycle pulse when results are final.
- `pass` out 1: 1 when the last sweep had zero mismatches.
- `table` out 16: captured truth table; bit i = `s` sampled at index i.
- `mismatch_count` out 5: mismatches in the last sweep, 0..16.
- `first_fail` out 4: lowest mismatching index; valid only when `first_fail_valid` = 1.
- `first_fail_valid` out 1: set when any mismatch has occurred in the current sweep.

## Operation
- States: IDLE, WAIT, SAMPLE, DONE.
- **Reset** (`rst_n` = 0 at an edge): state IDLE. Reset applies from any state, including mid-sweep, and takes effect at that edge. All of the following clear to 0:
  - idx, settle counter, latched expected
  - `x`, `y`, `w`, `z`, `busy`, `done`, `pass`
  - `table`, `mismatch_count`, `first_fail`, `first_fail_valid`
- **IDLE**:
  - idx = 0, so `x`/`y`/`w`/`z` = 0.
  - On `start` = 1: latch `expected`; clear `table`, `mismatch_count`, `first_fail`, `first_fail_valid`, `pass`; set idx = 0 and cnt = SETTLE; go to WAIT.
- **WAIT**:
  - `x`/`y`/`w`/`z` driven from the idx register.
  - cnt decrements each cycle; on the edge where cnt = 1, go to SAMPLE. WAIT therefore lasts exactly SETTLE cycles.
- **SAMPLE**: one cycle. At its closing edge:
  - `table[idx]` <= `s`.
  - If `s` != expected[idx]: increment `mismatch_count`. If `first_fail_valid` = 0, also set `first_fail` = idx and `first_fail_valid` = 1.
  - If idx = 15: go to DONE, with `pass` <= (final mismatch count == 0), including the current vector.
  - Otherwise: idx+1, cnt = SETTLE, go to WAIT.
- **DONE**:
  - `done` = 1 for exactly one cycle, then IDLE.
  - idx returns to 0 on entry to IDLE.
- `start` outside IDLE (WAIT, SAMPLE, DONE) is ignored; it is not queued.
- `start` held high re-triggers on the first IDLE cycle after DONE.
- Results (`table`, `pass`, counts) hold their values after DONE until the next accepted start or reset.
- `s` = x/z at a sample: store it in `table` as-is; it compares as mismatch-unknown (simulation only, not a design requirement).
- `mismatch_count` cannot overflow: at most 16 increments fit in 5 bits.

## Timing
- Edge E0 samples `start` in IDLE. `busy` is high after E0.
- Vector i is applied after edge E(i·(SETTLE+1)) and sampled at edge E((i+1)·(SETTLE+1)).
- The final sample occurs at edge E(16·(SETTLE+1)).
- `done` is high in the cycle after that edge; `busy` falls at the following edge. With SETTLE = 1, done follows E32.
- Accepted-start to next-start-acceptable: 16·(SETTLE+1)+2 edges.
- Inputs change only at clock edges. The function block is purely combinational, so SETTLE ≥ 1 guarantees a full cycle of settle.

## Test plan
- **Reset**: hold `rst_n` = 0 for 3 edges -> all outputs 0, `table` = 16'h0000, `busy` = 0.
- **Good sweep**: `fxy` connected, `expected` = 16'h3526, SETTLE = 1, start pulse -> `x`/`y`/`w`/`z` walk 0000..1111 every 2 cycles; `done` after E32; `table` = 16'h3526, `pass` = 1, `mismatch_count` = 0, `first_fail_valid` = 0.
- **Mismatch**: `fxy`, `expected` = 16'h3525 -> `table` = 16'h3526, `pass` = 0, `mismatch_count` = 2, `first_fail` = 0, `first_fail_valid` = 1.
- **Busy start**: pulse `start` again at E10 during a sweep -> ignored; exactly one `done`, at E32. Then hold `start` high -> a new sweep begins at the IDLE edge after DONE.
- **Reset mid-sweep**: assert `rst_n` = 0 at E10 -> `busy` = 0, `table` = 0, `x`/`y`/`w`/`z` = 0 after that edge. A new start then yields a full correct result.
- **Settle parameter**: SETTLE = 3, `s` tied to 1, `expected` = 16'hFFFF -> each vector held 4 cycles; `done` after E64; `pass` = 1, `table` = 16'hFFFF.
